// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mem_access_unit_pkg
// Description : Shared MEM-stage definitions: FSM state encoding, word
//               alignment mask and default datapath width.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package mem_access_unit_pkg;

   // Default data/address width of the pipeline
   localparam int DATA_W_DEFAULT = 32;

   // Low address bits that must be zero for a word access
   localparam logic [1:0] WORD_OFFSET_MASK = 2'b11;

   // Memory access controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage : mem_access_unit_pkg
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mem_access_unit
// Description : MEM-stage memory access controller. Turns EX/MEM load/store
//               control into a req/ack word-memory transaction, stalls the
//               upstream pipeline while the access is outstanding and returns
//               load data plus an error flag (misaligned or timeout).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEFAULT,
   parameter int TIMEOUT = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              MemRead_i,
   input  logic              MemWrite_i,
   input  logic [DATA_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic              stall_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              err_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [DATA_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   // Counter must reach TIMEOUT-1; keep at least one bit when disabled
   localparam int CNT_W_RAW = $clog2(TIMEOUT + 1);
   localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                req_q, req_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;

   logic                access;
   logic                aligned;
   logic                timeout_hit;

   assign access  = start_i & (MemRead_i | MemWrite_i);
   assign aligned = ((addr_i[1:0] & WORD_OFFSET_MASK) == 2'b00);

   // Timeout comparator only exists when a timeout is configured
   generate
      if (TIMEOUT != 0) begin : g_timeout_en
         assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
      end else begin : g_timeout_dis
         assign timeout_hit = 1'b0;
      end
   endgenerate

   // Stall covers the IDLE detect cycle and every BUSY cycle; never in reset
   assign stall_o = rst_i & ((state_q == ST_BUSY) |
                             ((state_q == ST_IDLE) & access & aligned));

   assign rdata_o     = rdata_q;
   assign err_o       = err_q;
   assign mem_req_o   = req_q;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;

   // Next-state and next-output logic; everything holds unless changed below
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (access && aligned) begin
               // Launch the request; a simultaneous read+write is a write
               addr_d  = {addr_i[DATA_W-1:2], 2'b00};
               wdata_d = wdata_i;
               we_d    = MemWrite_i;
               req_d   = 1'b1;
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = ST_BUSY;
            end else if (access) begin
               // Misaligned: fault for one cycle, never touch memory
               err_d   = 1'b1;
               rdata_d = '0;
            end else begin
               err_d   = 1'b0;
            end
         end

         ST_BUSY: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (mem_ack_i) begin
               // Ack has priority over a timeout in the same cycle
               req_d   = 1'b0;
               rdata_d = we_q ? '0 : mem_rdata_i;
               err_d   = 1'b0;
               state_d = ST_DONE;
            end else if (timeout_hit) begin
               req_d   = 1'b0;
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            // EX/MEM still shows the finished instruction: ignore inputs
            err_d   = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // State, counter and output registers with asynchronous active-low reset
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

endmodule : mem_access_unit
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit with TIMEOUT=4.
//               Each transaction's outcome (stall length, error, load data)
//               is predicted from the access rules before it is driven.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_mem_access_unit;

   localparam int TO = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        MemRead_i;
   logic        MemWrite_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        stall_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_rdata = 32'h0;   // rdata_o value the model says is held

   mem_access_unit #(
      .DATA_W  (32),
      .TIMEOUT (TO)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .MemRead_i   (MemRead_i),
      .MemWrite_i  (MemWrite_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .stall_o     (stall_o),
      .rdata_o     (rdata_o),
      .err_o       (err_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_ack_i   (mem_ack_i),
      .mem_rdata_i (mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   // One complete transaction. ack_at = BUSY cycle (1-based) on which memory
   // acks; 0 or anything beyond TO means memory never answers in time.
   // Entered and left 1 time unit after a rising edge with the DUT idle.
   task automatic do_access(input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int ack_at, input logic [31:0] mrd,
                            input logic bubble, input string tag);
      logic        aligned;
      logic        acked;
      int          n_busy;
      logic        exp_err;
      logic [31:0] exp_dat;
      logic [31:0] exp_addr;
      int          k;
      // Reference outcome from the access rules
      aligned  = (addr[1:0] == 2'b00);
      acked    = (ack_at >= 1) && (ack_at <= TO);
      n_busy   = acked ? ack_at : TO;
      exp_err  = aligned ? !acked : 1'b1;
      exp_dat  = (aligned && acked && !wr) ? mrd : 32'h0;
      exp_addr = {addr[31:2], 2'b00};

      start_i = 1'b1; MemRead_i = rd; MemWrite_i = wr;
      addr_i = addr; wdata_i = wd; mem_ack_i = 1'b0; mem_rdata_i = $urandom;
      #1;
      checks++;
      if (stall_o !== aligned) begin
         errors++; $display("FAIL %s idle_stall: got %b want %b", tag, stall_o, aligned);
      end
      checks++;
      if (mem_req_o !== 1'b0) begin
         errors++; $display("FAIL %s idle_req: got %b want 0", tag, mem_req_o);
      end
      @(posedge clk_i); #1;

      if (!aligned) begin
         checks++;
         if (err_o !== 1'b1 || rdata_o !== 32'h0 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL %s misaligned: got err=%b rdata=%h req=%b want err=1 rdata=0 req=0",
                     tag, err_o, rdata_o, mem_req_o);
         end
         start_i = 1'b0;
         #1;
         checks++;
         if (stall_o !== 1'b0) begin
            errors++; $display("FAIL %s misaligned_stall: got %b want 0", tag, stall_o);
         end
         @(posedge clk_i); #1;
         checks++;
         if (err_o !== 1'b0 || rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL %s err_one_cycle: got err=%b rdata=%h want err=0 rdata=0",
                     tag, err_o, rdata_o);
         end
         exp_rdata = 32'h0;
         return;
      end

      // BUSY: request must be held stable until memory answers or times out
      k = 0;
      while (stall_o === 1'b1 && k < TO + 4) begin
         k++;
         mem_ack_i   = (k == ack_at);
         mem_rdata_i = (k == ack_at) ? mrd : $urandom;
         #1;
         checks++;
         if (mem_req_o !== 1'b1 || mem_we_o !== wr || mem_addr_o !== exp_addr ||
             mem_wdata_o !== wd) begin
            errors++;
            $display("FAIL %s busy%0d_req: got req=%b we=%b addr=%h wdata=%h want 1 %b %h %h",
                     tag, k, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, wr, exp_addr, wd);
         end
         @(posedge clk_i); #1;
         mem_ack_i = 1'b0;
      end
      checks++;
      if (k != n_busy) begin
         errors++; $display("FAIL %s busy_cycles: got %0d want %0d", tag, k, n_busy);
      end

      // DONE: result visible, stall released, no new request
      checks++;
      if (stall_o !== 1'b0 || mem_req_o !== 1'b0 || err_o !== exp_err || rdata_o !== exp_dat) begin
         errors++;
         $display("FAIL %s done: got stall=%b req=%b err=%b rdata=%h want 0 0 %b %h",
                  tag, stall_o, mem_req_o, err_o, rdata_o, exp_err, exp_dat);
      end
      exp_rdata = exp_dat;

      // A stray ack in DONE must not disturb the held result
      mem_ack_i = 1'b1; mem_rdata_i = $urandom;
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
      if (bubble) start_i = 1'b0;
      #1;
      checks++;
      if (mem_req_o !== 1'b0 || err_o !== 1'b0 || rdata_o !== exp_rdata ||
          (bubble && stall_o !== 1'b0)) begin
         errors++;
         $display("FAIL %s after_done: got req=%b err=%b rdata=%h stall=%b want 0 0 %h %b",
                  tag, mem_req_o, err_o, rdata_o, stall_o, exp_rdata, 1'b0);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b0; start_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0;
      addr_i = 32'h10; wdata_i = 32'h0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
      for (int c = 0; c < 2; c++) begin
         #2;
         checks++;
         if (stall_o !== 1'b0 || mem_req_o !== 1'b0 || mem_we_o !== 1'b0 ||
             mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0 || rdata_o !== 32'h0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset%0d: got stall=%b req=%b we=%b addr=%h wdata=%h rdata=%h err=%b want all 0",
                     c, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, rdata_o, err_o);
         end
         @(posedge clk_i);
      end
      #1;
      rst_i = 1'b1; start_i = 1'b0;
      @(posedge clk_i); #1;
   endtask

   task automatic test_load_basic();
      do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'hDEAD_BEEF, 1'b1, "load_ack1");
   endtask

   task automatic test_store_delay();
      do_access(1'b0, 1'b1, 32'h0000_0024, 32'h1234_5678, 3, $urandom, 1'b1, "store_ack3");
   endtask

   task automatic test_misaligned();
      do_access(1'b1, 1'b0, 32'h0000_0013, 32'h0, 1, 32'hFFFF_FFFF, 1'b1, "misaligned");
   endtask

   task automatic test_timeout();
      do_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, 32'hA5A5_A5A5, 1'b1, "timeout");
      do_access(1'b1, 1'b0, 32'h0000_0044, 32'h0, TO, 32'hCAFE_F00D, 1'b1, "ack_at_limit");
   endtask

   task automatic test_back_to_back();
      do_access(1'b1, 1'b0, 32'h0000_0000, 32'h0, 1, 32'h1111_2222, 1'b0, "b2b_0");
      do_access(1'b1, 1'b0, 32'h0000_0004, 32'h0, 1, 32'h3333_4444, 1'b1, "b2b_4");
      // Bubble: load fields present but start_i low
      MemRead_i = 1'b1; addr_i = 32'h8;
      for (int c = 0; c < 3; c++) begin
         mem_ack_i = (c == 1);
         #1;
         checks++;
         if (stall_o !== 1'b0 || mem_req_o !== 1'b0 || rdata_o !== exp_rdata) begin
            errors++;
            $display("FAIL bubble%0d: got stall=%b req=%b rdata=%h want 0 0 %h",
                     c, stall_o, mem_req_o, rdata_o, exp_rdata);
         end
         @(posedge clk_i); #1;
      end
      mem_ack_i = 1'b0;
   endtask

   task automatic test_async_reset();
      start_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0; addr_i = 32'h80;
      @(posedge clk_i); #1;   // BUSY 1
      @(posedge clk_i); #3;   // mid BUSY 2, no ack
      rst_i = 1'b0;
      #1;
      checks++;
      if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || err_o !== 1'b0 || rdata_o !== 32'h0) begin
         errors++;
         $display("FAIL async_reset: got req=%b stall=%b err=%b rdata=%h want 0 0 0 0",
                  mem_req_o, stall_o, err_o, rdata_o);
      end
      start_i = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      exp_rdata = 32'h0;
      @(posedge clk_i); #1;
      do_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 2, 32'h0BAD_CAFE, 1'b1, "post_reset_load");
   endtask

   task automatic test_random();
      for (int n = 0; n < 24; n++) begin
         int          sel;
         logic        rd, wr;
         logic [31:0] a;
         sel = $urandom_range(0, 2);
         rd  = (sel != 1);
         wr  = (sel != 0);
         a   = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         do_access(rd, wr, a, $urandom, $urandom_range(0, TO + 1), $urandom,
                   1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
      end
   endtask

   initial begin
      test_reset();
      test_load_basic();
      test_store_delay();
      test_misaligned();
      test_timeout();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute bound so a stuck design cannot hang the run
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_mem_access_unit
`default_nettype wire
